// File: rtl/sdio_rsp_rx.sv
// sdio_rsp_rx
//   Receives an SD/SDIO command-line response.
//   Bits arrive on up to two lanes per cycle; lane [1] is earlier than lane [0].
//   The receiver waits for a start bit. It then collects a 48-bit or 136-bit
//   frame and checks the framing bits and CRC7. It reports one result per request.
//
// Parameters
//   LGTIMEOUT  log2 of the start-bit wait limit, in clock cycles
//   OPT_R2     1: accept 136-bit R2 responses; 0: an R2 request ends in a frame error
//
// Ports
//   i_clk        clock, rising edge
//   i_reset_n    synchronous active-low reset
//   i_start      one-cycle request, honoured only when idle
//   i_rsp_type   00 none, 01 48-bit with CRC, 10 136-bit R2, 11 48-bit without CRC
//   i_abort      return to idle with no result
//   i_cmd_strb   per-lane valid strobes
//   i_cmd_data   per-lane CMD bits
//   o_busy       waiting for a start bit or receiving a frame
//   o_done       one-cycle result strobe
//   o_err        00 ok, 01 timeout, 10 CRC error, 11 frame error
//   o_rsp_index  index field of the last 48-bit response
//   o_rsp_arg    argument field of the last 48-bit response
//   o_rsp_long   bits [127:8] of the last R2 response
module sdio_rsp_rx #(
  parameter int LGTIMEOUT = 23,
  parameter bit OPT_R2    = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_start,
  input  logic [1:0]   i_rsp_type,
  input  logic         i_abort,
  input  logic [1:0]   i_cmd_strb,
  input  logic [1:0]   i_cmd_data,
  output logic         o_busy,
  output logic         o_done,
  output logic [1:0]   o_err,
  output logic [5:0]   o_rsp_index,
  output logic [31:0]  o_rsp_arg,
  output logic [119:0] o_rsp_long
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RECV, S_DONE} state_t;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_TMO   = 2'b01;
  localparam logic [1:0] ERR_CRC   = 2'b10;
  localparam logic [1:0] ERR_FRAME = 2'b11;

  localparam logic [LGTIMEOUT-1:0] TMO_LOAD = '1;
  localparam logic [LGTIMEOUT-1:0] TMO_ONE  = 1;

  state_t               state, state_n;
  logic [1:0]           rsp_type, rsp_type_n;
  logic [7:0]           bit_cnt, bit_cnt_n;
  logic [6:0]           crc, crc_n;
  logic [119:0]         sreg, sreg_n;
  logic [LGTIMEOUT-1:0] tmo, tmo_n;
  logic                 frame_err, frame_err_n;
  logic                 crc_err, crc_err_n;
  logic [1:0]           err_n;
  logic                 ld_short, ld_long;
  logic                 is_r2;
  logic [7:0]           flen, crc_top, idx;
  logic                 b;

  // One serial CRC7 step, x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic d);
    return {c[5:0], 1'b0} ^ ({7{d ^ c[6]}} & 7'h09);
  endfunction

  always_comb begin
    state_n     = state;
    rsp_type_n  = rsp_type;
    bit_cnt_n   = bit_cnt;
    crc_n       = crc;
    sreg_n      = sreg;
    tmo_n       = tmo;
    frame_err_n = frame_err;
    crc_err_n   = crc_err;
    err_n       = ERR_OK;
    ld_short    = 1'b0;
    ld_long     = 1'b0;
    is_r2       = (rsp_type == 2'b10);
    flen        = is_r2 ? 8'd136 : 8'd48;
    crc_top     = is_r2 ? 8'd127 : 8'd47;
    idx         = '0;
    b           = 1'b0;

    case (state)
      S_IDLE: begin
        if (i_start) begin
          rsp_type_n = i_rsp_type;
          if (i_rsp_type == 2'b00) begin
            state_n = S_DONE;
            err_n   = ERR_OK;
          end else if (i_rsp_type == 2'b10 && !OPT_R2) begin
            state_n = S_DONE;
            err_n   = ERR_FRAME;
          end else begin
            state_n = S_WAIT;
            tmo_n   = TMO_LOAD;
          end
        end
      end

      S_DONE: state_n = S_IDLE;

      default: begin
        // Lane [1] first, then lane [0]. A start bit found on lane [1] switches
        // to RECV, so a valid lane [0] bit becomes the next frame bit. Once the
        // end bit is taken (state_n == DONE), any later bit in the cycle is dropped.
        for (int lane = 1; lane >= 0; lane--) begin
          if (i_cmd_strb[lane[0]] && state_n != S_DONE) begin
            b = i_cmd_data[lane[0]];
            if (state_n == S_WAIT && !b) begin
              state_n     = S_RECV;
              bit_cnt_n   = '0;
              crc_n       = '0;
              frame_err_n = 1'b0;
              crc_err_n   = 1'b0;
            end
            if (state_n == S_RECV) begin
              // idx is the frame bit number; the start bit is flen-1.
              idx       = flen - 8'd1 - bit_cnt_n;
              bit_cnt_n = bit_cnt_n + 8'd1;
              if (idx == flen - 8'd2 && b)
                frame_err_n = 1'b1;
              // R2 and R3 carry a reserved all-ones field after the transmission bit.
              if (rsp_type[1] && idx <= flen - 8'd3 && idx >= flen - 8'd8 && !b)
                frame_err_n = 1'b1;
              if (idx >= 8'd8 && idx <= crc_top)
                crc_n = crc7_step(crc_n, b);
              if (idx >= 8'd1 && idx <= 8'd7) begin
                if (rsp_type != 2'b11 && b != crc_n[6])
                  crc_err_n = 1'b1;
                crc_n = {crc_n[5:0], 1'b0};
              end
              // Keep the most recent 120 bits above the CRC. This leaves
              // index/arg in [37:0] for short frames and bits 127:8 for R2.
              if (idx >= 8'd8)
                sreg_n = {sreg_n[118:0], b};
              if (idx == 8'd0) begin
                if (!b)
                  frame_err_n = 1'b1;
                state_n  = S_DONE;
                err_n    = frame_err_n ? ERR_FRAME : (crc_err_n ? ERR_CRC : ERR_OK);
                ld_short = !is_r2;
                ld_long  = is_r2;
              end
            end
          end
        end
        if (state == S_WAIT && state_n == S_WAIT) begin
          tmo_n = tmo - TMO_ONE;
          if (tmo_n == '0) begin
            state_n = S_DONE;
            err_n   = ERR_TMO;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state       <= S_IDLE;
      rsp_type    <= 2'b00;
      bit_cnt     <= '0;
      crc         <= '0;
      tmo         <= '0;
      frame_err   <= 1'b0;
      crc_err     <= 1'b0;
      o_err       <= ERR_OK;
      o_rsp_index <= '0;
      o_rsp_arg   <= '0;
      o_rsp_long  <= '0;
    end else if (i_abort) begin
      state <= S_IDLE;
    end else begin
      state     <= state_n;
      rsp_type  <= rsp_type_n;
      bit_cnt   <= bit_cnt_n;
      crc       <= crc_n;
      tmo       <= tmo_n;
      frame_err <= frame_err_n;
      crc_err   <= crc_err_n;
      // DONE is only entered from another state, so this runs once per result.
      if (state_n == S_DONE)
        o_err <= err_n;
      if (ld_short) begin
        o_rsp_index <= sreg_n[37:32];
        o_rsp_arg   <= sreg_n[31:0];
      end
      if (ld_long)
        o_rsp_long <= sreg_n;
    end
  end

  // The shift register is never read before a full frame has refilled it.
  always_ff @(posedge i_clk) begin
    sreg <= sreg_n;
  end

  assign o_busy = (state == S_WAIT) || (state == S_RECV);
  assign o_done = (state == S_DONE);

endmodule

// File: tb/tb_sdio_rsp_rx.sv
// Testbench for sdio_rsp_rx: directed cases plus randomized frames against a
// whole-frame reference model (CRC7 by polynomial long division).
module tb_sdio_rsp_rx;

  logic         clk = 1'b0;
  logic         rst_n, start, abort;
  logic [1:0]   rsp_type, strb, data;
  logic         busy, done;
  logic [1:0]   err;
  logic [5:0]   rsp_index;
  logic [31:0]  rsp_arg;
  logic [119:0] rsp_long;

  int n_checks = 0;
  int n_pass   = 0;

  // Model-held results of the last completed request.
  logic [1:0]   m_err;
  logic [5:0]   m_index;
  logic [31:0]  m_arg;
  logic [119:0] m_long;

  logic [135:0] f, f2;
  logic [127:0] rlg4;
  logic [1:0]   rty;
  int           c, pos, flen, k_done, n_done;

  always #5 clk = ~clk;

  sdio_rsp_rx #(.LGTIMEOUT(4), .OPT_R2(1'b1)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_start     (start),
    .i_rsp_type  (rsp_type),
    .i_abort     (abort),
    .i_cmd_strb  (strb),
    .i_cmd_data  (data),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_rsp_index (rsp_index),
    .o_rsp_arg   (rsp_arg),
    .o_rsp_long  (rsp_long)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc7_div(input logic [135:0] fb, input int hi, input int lo);
    logic [142:0] r;
    int n;
    n = hi - lo + 1;
    r = '0;
    for (int i = 0; i < n; i++) r[n + 6 - i] = fb[hi - i];
    for (int i = n + 6; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [135:0] build(input logic [1:0] typ, input logic [5:0] ix,
                                         input logic [31:0] ag, input logic [119:0] lg);
    logic [135:0] fr;
    fr = '0;
    if (typ == 2'b10) begin
      fr[135:128] = {2'b00, 6'h3F};
      fr[127:8]   = lg;
      fr[7:1]     = crc7_div(fr, 127, 8);
    end else begin
      fr[47:40] = {2'b00, (typ == 2'b11) ? 6'h3F : ix};
      fr[39:8]  = ag;
      fr[7:1]   = (typ == 2'b11) ? 7'h7F : crc7_div(fr, 47, 8);
    end
    fr[0] = 1'b1;
    return fr;
  endfunction

  function automatic logic [1:0] model_err(input logic [1:0] typ, input logic [135:0] fb);
    int len;
    bit ferr, cerr;
    len  = (typ == 2'b10) ? 136 : 48;
    ferr = fb[len - 2] || !fb[0];
    if (typ != 2'b01 && fb[len - 3 -: 6] != 6'h3F) ferr = 1'b1;
    cerr = 1'b0;
    if (typ != 2'b11)
      cerr = (crc7_div(fb, (typ == 2'b10) ? 127 : 47, 8) != fb[7:1]);
    return ferr ? 2'b11 : (cerr ? 2'b10 : 2'b00);
  endfunction

  // mode 0: random strobes, 1: lane [1] only, 2: both lanes every cycle.
  task automatic run_frame(input logic [1:0] typ, input logic [135:0] fb, input int pre,
                           input int mode, input bit noise);
    bit         q[$];
    int         len, placed;
    bit         early;
    logic [1:0] s, e_err;
    len    = (typ == 2'b10) ? 136 : 48;
    placed = 0;
    early  = 1'b0;
    e_err  = model_err(typ, fb);
    for (int i = 0; i < pre; i++) q.push_back(1'b1);
    for (int i = len - 1; i >= 0; i--) q.push_back(fb[i]);
    @(negedge clk);
    start = 1'b1; rsp_type = typ; strb = 2'b00;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_wait", busy, 1'b1);
    while (q.size() > 0) begin
      case (mode)
        1:       s = 2'b10;
        2:       s = 2'b11;
        default: s = 2'($urandom_range(0, 3));
      endcase
      if (placed <= pre && s == 2'b00) s = 2'b01;
      data = 2'($urandom_range(0, 3));
      for (int l = 1; l >= 0; l--)
        if (s[l]) begin
          if (q.size() > 0) begin data[l] = q.pop_front(); placed++; end
        end
      strb     = s;
      start    = noise & 1'($urandom_range(0, 1));
      rsp_type = 2'($urandom_range(0, 3));
      @(negedge clk);
      if (done && q.size() > 0) early = 1'b1;
    end
    strb = 2'b00; start = 1'b0;
    m_err = e_err;
    if (typ == 2'b10) m_long = fb[127:8];
    else begin m_index = fb[45:40]; m_arg = fb[39:8]; end
    check_eq("early_done", early, 1'b0);
    check_eq("done", done, 1'b1);
    check_eq("err", err, m_err);
    check_eq("busy_done", busy, 1'b0);
    check_eq("index", rsp_index, m_index);
    check_eq("arg", rsp_arg, m_arg);
    check_eq("long", rsp_long, m_long);
    @(negedge clk);
    check_eq("done_one_cycle", done, 1'b0);
    check_eq("err_hold", err, m_err);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rsp_type = 2'b00; strb = 2'b00; data = 2'b00;
    m_err = 2'b00; m_index = '0; m_arg = '0; m_long = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_err", err, 2'b00);
    check_eq("rst_index", rsp_index, 6'h00);
    check_eq("rst_arg", rsp_arg, 32'h0);
    check_eq("rst_long", rsp_long, 120'h0);
    rst_n = 1'b1;

    // No-response request completes immediately.
    @(negedge clk); start = 1'b1; rsp_type = 2'b00;
    @(negedge clk); start = 1'b0;
    check_eq("none_done", done, 1'b1);
    check_eq("none_err", err, 2'b00);
    check_eq("none_busy", busy, 1'b0);

    // Known-good R1 frame on a single lane.
    f = build(2'b01, 6'h11, 32'h0000_0900, '0);
    run_frame(2'b01, f, 2, 1, 1'b0);
    check_eq("r1_err_ok", err, 2'b00);
    check_eq("r1_index", rsp_index, 6'h11);
    check_eq("r1_arg", rsp_arg, 32'h0000_0900);

    f2 = f; f2[13] = ~f2[13];
    run_frame(2'b01, f2, 1, 1, 1'b0);
    check_eq("r1_crc_err", err, 2'b10);
    f2 = f; f2[0] = 1'b0;
    run_frame(2'b01, f2, 0, 1, 1'b0);
    check_eq("r1_end_err", err, 2'b11);

    // R2 on both lanes; the first pair is {1,0}, so the start bit is on lane [0].
    f = build(2'b10, '0, '0, 120'h0123456789ABCDEF0123456789ABCD);
    run_frame(2'b10, f, 1, 2, 1'b0);
    check_eq("r2_err_ok", err, 2'b00);
    check_eq("r2_long", rsp_long, 120'h0123456789ABCDEF0123456789ABCD);

    // Randomized frames of all types, with occasional corruption.
    for (int t = 0; t < 40; t++) begin
      rty  = 2'($urandom_range(1, 3));
      rlg4 = {$urandom, $urandom, $urandom, $urandom};
      f    = build(rty, 6'($urandom_range(0, 63)), $urandom, rlg4[119:0]);
      flen = (rty == 2'b10) ? 136 : 48;
      c    = $urandom_range(0, 5);
      case (c)
        1: begin pos = $urandom_range(1, flen - 2); f[pos] = ~f[pos]; end
        2: f[0] = 1'b0;
        3: f[flen - 2] = 1'b1;
        4: begin pos = $urandom_range(1, 7); f[pos] = ~f[pos]; end
        default: ;
      endcase
      run_frame(rty, f, $urandom_range(0, 3), 0, 1'b1);
    end

    // Start-bit timeout with CMD held high: 2^4-1 cycles.
    @(negedge clk); start = 1'b1; rsp_type = 2'b01; strb = 2'b11; data = 2'b11;
    @(negedge clk); start = 1'b0;
    k_done = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin k_done = k; break; end
    end
    check_eq("tmo_latency", k_done, 15);
    check_eq("tmo_err", err, 2'b01);
    m_err = 2'b01;
    @(negedge clk);
    check_eq("tmo_busy_after", busy, 1'b0);
    strb = 2'b00;

    // Abort wins over a start in the same cycle.
    @(negedge clk); start = 1'b1; rsp_type = 2'b00; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check_eq("abort_start_done", done, 1'b0);
    check_eq("abort_start_err", err, m_err);

    // Abort at bit 20 of a 48-bit frame.
    f = build(2'b01, 6'h2A, 32'hDEADBEEF, '0);
    @(negedge clk); start = 1'b1; rsp_type = 2'b01; strb = 2'b00;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      strb = 2'b10; data = {f[47 - i], 1'b0};
      @(negedge clk);
    end
    abort = 1'b1; data = {f[27], 1'b0};
    @(negedge clk); abort = 1'b0;
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_done", done, 1'b0);
    n_done = 0;
    for (int i = 21; i < 48; i++) begin
      data = {f[47 - i], 1'b0};
      @(negedge clk);
      if (done) n_done++;
    end
    strb = 2'b00;
    check_eq("abort_no_done", n_done, 0);
    check_eq("abort_err_hold", err, m_err);
    check_eq("abort_index_hold", rsp_index, m_index);
    check_eq("abort_arg_hold", rsp_arg, m_arg);
    check_eq("abort_long_hold", rsp_long, m_long);

    // Reset pulsed while waiting for a start bit.
    @(negedge clk); start = 1'b1; rsp_type = 2'b01;
    @(negedge clk); start = 1'b0;
    check_eq("wait_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_done", done, 1'b0);
    check_eq("mid_rst_err", err, 2'b00);
    check_eq("mid_rst_index", rsp_index, 6'h00);
    check_eq("mid_rst_arg", rsp_arg, 32'h0);
    check_eq("mid_rst_long", rsp_long, 120'h0);
    @(negedge clk);
    check_eq("mid_rst_no_done", done, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
